// File: rtl/can_rx_mailbox.sv
// Receive mailbox for the TinyQV CAN peripheral: acceptance filters, a frame FIFO
// with overflow accounting, and threshold/overflow interrupts on the peripheral bus.
module can_rx_mailbox #(
    parameter int DEPTH = 4,
    parameter int NFILT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frm_valid,
    input  logic [28:0] frm_id,
    input  logic        frm_ext,
    input  logic        frm_rtr,
    input  logic [3:0]  frm_dlc,
    input  logic [63:0] frm_data,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] FEN_MASK = 4'((1 << NFILT) - 1);

    logic [31:0]   hid_mem  [DEPTH];
    logic [3:0]    dlc_mem  [DEPTH];
    logic [63:0]   data_mem [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic [7:0]    dropcnt;
    logic [3:0]    thresh;
    logic [3:0]    fen;
    logic          tie, oie;
    logic          code_ext [4];
    logic [28:0]   code_id  [4];
    logic          mask_ext [4];
    logic [28:0]   mask_id  [4];

    logic          wr32, cmd_wr, pop_cmd, clr, flush;
    logic          filt_sel;
    logic [1:0]    fidx;
    logic          hit, accept, accept_frm;
    logic          full, do_push, do_pop, drop;
    logic [4:0]    cnt5;
    logic [3:0]    thr_eff;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign wr32     = (data_write_n == 2'b10);
    assign cmd_wr   = wr32 && (address == 6'h00);
    assign pop_cmd  = cmd_wr && data_in[0];
    assign clr      = cmd_wr && data_in[1];
    assign flush    = cmd_wr && data_in[2];
    assign filt_sel = address[5] && (address[1:0] == 2'b00) && (int'(address[4:3]) < NFILT);
    assign fidx     = address[4:3];

    // Filters see the register values from before any same-edge write.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (fen[k] && (((frm_id ^ code_id[k]) & mask_id[k]) == 29'd0) &&
                (!mask_ext[k] || (frm_ext == code_ext[k])))
                hit = 1'b1;
        end
        accept = (fen == 4'd0) || hit;
    end

    assign full       = (count == CW'(DEPTH));
    assign accept_frm = frm_valid && accept && !flush;
    assign do_pop     = pop_cmd && (count != '0);
    assign do_push    = accept_frm && (!full || do_pop);
    assign drop       = accept_frm && full && !do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            dropcnt <= 8'd0;
            thresh  <= 4'd1;
            fen     <= 4'd0;
            tie     <= 1'b0;
            oie     <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                code_ext[k] <= 1'b0;
                code_id[k]  <= 29'd0;
                mask_ext[k] <= 1'b0;
                mask_id[k]  <= 29'd0;
            end
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(do_push) - CW'(do_pop);
            end
            // A drop in the same cycle as a clear restarts the tally at one.
            if (drop) begin
                ovf     <= 1'b1;
                dropcnt <= clr ? 8'd1 : sat_inc(dropcnt);
            end else if (clr) begin
                ovf     <= 1'b0;
                dropcnt <= 8'd0;
            end
            if (wr32 && address == 6'h04) begin
                thresh <= data_in[3:0];
                fen    <= data_in[11:8] & FEN_MASK;
                tie    <= data_in[16];
                oie    <= data_in[17];
            end
            for (int k = 0; k < 4; k++) begin
                if (wr32 && filt_sel && int'(fidx) == k) begin
                    if (address[2]) begin
                        mask_ext[k] <= data_in[31];
                        mask_id[k]  <= data_in[28:0];
                    end else begin
                        code_ext[k] <= data_in[31];
                        code_id[k]  <= data_in[28:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            hid_mem[wr_ptr]  <= {frm_ext, frm_rtr, 1'b0, frm_id};
            dlc_mem[wr_ptr]  <= frm_dlc;
            data_mem[wr_ptr] <= frm_data;
        end
    end

    assign cnt5    = 5'(count);
    assign thr_eff = (thresh == 4'd0) ? 4'd1 : thresh;
    assign user_interrupt = (tie && (cnt5 >= {1'b0, thr_eff})) || (oie && ovf);
    assign data_ready = 1'b1;

    always_comb begin
        data_out = 32'd0;
        if (data_read_n != 2'b11) begin
            case (address)
                6'h00: data_out = {8'd0, dropcnt, 6'd0, (count != '0), ovf, 3'd0, cnt5};
                6'h04: data_out = {14'd0, oie, tie, 4'd0, fen, 4'd0, thresh};
                6'h08: data_out = (count != '0) ? hid_mem[rd_ptr] : 32'd0;
                6'h0C: data_out = (count != '0) ? {28'd0, dlc_mem[rd_ptr]} : 32'd0;
                6'h10: data_out = (count != '0) ? data_mem[rd_ptr][31:0] : 32'd0;
                6'h14: data_out = (count != '0) ? data_mem[rd_ptr][63:32] : 32'd0;
                default: begin
                    if (filt_sel)
                        data_out = address[2] ? {mask_ext[fidx], 2'b00, mask_id[fidx]}
                                              : {code_ext[fidx], 2'b00, code_id[fidx]};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_can_rx_mailbox.sv
// Scoreboard bench for can_rx_mailbox: a queue model of accepted frames is updated
// as stimulus is driven and compared against the head registers on every pop.
module tb_can_rx_mailbox;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] hid;
        logic [3:0]  dlc;
        logic [63:0] data;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frm_valid = 1'b0;
    logic [28:0] frm_id = '0;
    logic        frm_ext = 1'b0;
    logic        frm_rtr = 1'b0;
    logic [3:0]  frm_dlc = '0;
    logic [63:0] frm_data = '0;
    logic [5:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    can_rx_mailbox #(.DEPTH(DEPTH), .NFILT(2)) dut (
        .clk(clk), .rst_n(rst_n), .frm_valid(frm_valid), .frm_id(frm_id),
        .frm_ext(frm_ext), .frm_rtr(frm_rtr), .frm_dlc(frm_dlc), .frm_data(frm_data),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
        .user_interrupt(user_interrupt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    frame_t      q[$];
    logic        m_ovf = 1'b0;
    logic [7:0]  m_drop = 8'd0;
    logic [3:0]  m_thresh = 4'd1;
    logic [1:0]  m_fen = 2'd0;
    logic        m_tie = 1'b0, m_oie = 1'b0;
    logic [31:0] m_code [2] = '{32'd0, 32'd0};
    logic [31:0] m_mask [2] = '{32'd0, 32'd0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_accept(input logic [28:0] id, input logic ext);
        logic h;
        h = 1'b0;
        for (int k = 0; k < 2; k++)
            if (m_fen[k] && (((id ^ m_code[k][28:0]) & m_mask[k][28:0]) == 29'd0) &&
                (!m_mask[k][31] || ext == m_code[k][31]))
                h = 1'b1;
        return (m_fen == 2'd0) || h;
    endfunction

    function automatic logic m_irq();
        int thr;
        thr = (m_thresh == 4'd0) ? 1 : int'(m_thresh);
        return (m_tie && q.size() >= thr) || (m_oie && m_ovf);
    endfunction

    task automatic rd(input logic [5:0] a, output logic [31:0] v);
        address = a;
        data_read_n = 2'b10;
        #1;
        v = data_out;
        data_read_n = 2'b11;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] v;
        settle();
        rd(6'h00, v);
        chk({tag, ".status"}, v, {8'd0, m_drop, 6'd0, (q.size() != 0), m_ovf, 3'd0, 5'(q.size())});
        chk({tag, ".irq"}, {31'd0, user_interrupt}, {31'd0, m_irq()});
    endtask

    task automatic check_head(input string tag);
        logic [31:0] v;
        frame_t f;
        f = (q.size() != 0) ? q[0] : '0;
        settle();
        rd(6'h08, v); chk({tag, ".head_id"}, v, f.hid);
        rd(6'h0C, v); chk({tag, ".head_dlc"}, v, {28'd0, f.dlc});
        rd(6'h10, v); chk({tag, ".head_d0"}, v, f.data[31:0]);
        rd(6'h14, v); chk({tag, ".head_d1"}, v, f.data[63:32]);
    endtask

    task automatic reg_write(input logic [5:0] a, input logic [31:0] d);
        frame_t f;
        address = a;
        data_in = d;
        data_write_n = 2'b10;
        @(posedge clk);
        #1;
        data_write_n = 2'b11;
        case (a)
            6'h00: begin
                if (d[2]) q.delete();
                else if (d[0] && q.size() != 0) f = q.pop_front();
                if (d[1]) begin m_ovf = 1'b0; m_drop = 8'd0; end
            end
            6'h04: begin
                m_thresh = d[3:0]; m_fen = d[9:8]; m_tie = d[16]; m_oie = d[17];
            end
            6'h20: m_code[0] = d & 32'h9FFF_FFFF;
            6'h24: m_mask[0] = d & 32'h9FFF_FFFF;
            6'h28: m_code[1] = d & 32'h9FFF_FFFF;
            6'h2C: m_mask[1] = d & 32'h9FFF_FFFF;
            default: ;
        endcase
    endtask

    // Frame pulse, optionally with a COMMAND write on the same edge.
    task automatic push(input logic [28:0] id, input logic ext, input logic rtr,
                        input logic [3:0] dlc, input logic [63:0] d, input logic [2:0] cmd);
        frame_t f, g;
        logic acc;
        acc = m_accept(id, ext);
        f.hid = {ext, rtr, 1'b0, id};
        f.dlc = dlc;
        f.data = d;
        frm_id = id; frm_ext = ext; frm_rtr = rtr; frm_dlc = dlc; frm_data = d;
        frm_valid = 1'b1;
        if (cmd != 3'd0) begin
            address = 6'h00; data_in = {29'd0, cmd}; data_write_n = 2'b10;
        end
        @(posedge clk);
        #1;
        frm_valid = 1'b0;
        data_write_n = 2'b11;
        if (cmd[2]) q.delete();
        else begin
            if (cmd[0] && q.size() != 0) g = q.pop_front();
            if (cmd[1]) begin m_ovf = 1'b0; m_drop = 8'd0; end
            if (acc) begin
                if (q.size() < DEPTH) q.push_back(f);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                end
            end
        end
    endtask

    task automatic pop_chk(input string tag);
        check_head(tag);
        reg_write(6'h00, 32'd1);
    endtask

    function automatic logic [63:0] fdata(input int i);
        return {32'hA5A5_0000 | 32'(i), 32'h0000_1000 + 32'(i)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        check_status("reset");
        check_head("reset");
        rd(6'h04, v); chk("reset.ctrl", v, 32'h0000_0001);
        chk("reset.ready", {31'd0, data_ready}, 32'd1);
        #1;
        chk("idle.data_out", data_out, 32'd0);

        push(29'h123, 1'b0, 1'b0, 4'd2, 64'h0000_BEEF, 3'd0);
        check_status("push1");
        pop_chk("push1");
        check_status("pop1");
        check_head("pop1");

        reg_write(6'h20, 32'h0000_0100);
        reg_write(6'h24, 32'h0000_0700);
        reg_write(6'h04, 32'h0000_0101);
        settle();
        rd(6'h24, v); chk("mask0.rb", v, 32'h0000_0700);
        push(29'h1AB, 1'b0, 1'b0, 4'd1, fdata(1), 3'd0);
        push(29'h2AB, 1'b0, 1'b0, 4'd1, fdata(2), 3'd0);
        push(29'h1FF, 1'b0, 1'b1, 4'd0, fdata(3), 3'd0);
        check_status("filt");
        pop_chk("filt.a");
        pop_chk("filt.b");
        check_status("filt.empty");

        reg_write(6'h04, 32'h0000_0001);
        for (int i = 0; i < 6; i++)
            push(29'h300 + 29'(i), 1'b0, 1'b0, 4'(i + 1), fdata(10 + i), 3'd0);
        check_status("ovf");
        check_head("ovf");
        reg_write(6'h04, 32'h0002_0001);
        check_status("ovf.irq");
        reg_write(6'h00, 32'h0000_0002);
        check_status("clr");

        push(29'h3FE, 1'b0, 1'b0, 4'd8, fdata(20), 3'd1);
        check_status("fullpp");
        check_head("fullpp");

        push(29'h3FD, 1'b0, 1'b0, 4'd3, fdata(21), 3'd2);
        check_status("clr_ovf");

        reg_write(6'h00, 32'h0000_0004);
        reg_write(6'h04, 32'h0001_0003);
        push(29'h050, 1'b0, 1'b0, 4'd1, fdata(30), 3'd0);
        push(29'h051, 1'b0, 1'b0, 4'd1, fdata(31), 3'd0);
        check_status("thr2");
        push(29'h052, 1'b0, 1'b0, 4'd1, fdata(32), 3'd0);
        check_status("thr3");
        pop_chk("thr.pop");
        check_status("thr.after");

        reg_write(6'h00, 32'h0000_0006);
        reg_write(6'h20, 32'h0000_0000);
        reg_write(6'h24, 32'h8000_0000);
        reg_write(6'h04, 32'h0000_0101);
        push(29'h1ABCDEF, 1'b1, 1'b0, 4'd4, fdata(40), 3'd0);
        check_status("extrej");
        push(29'h011, 1'b0, 1'b0, 4'd5, fdata(41), 3'd0);
        push(29'h012, 1'b0, 1'b0, 4'd5, fdata(42), 3'd0);
        push(29'h013, 1'b0, 1'b0, 4'd5, fdata(43), 3'd0);
        check_status("pre_flush");
        check_head("pre_flush");
        push(29'h014, 1'b0, 1'b0, 4'd5, fdata(44), 3'd4);
        check_status("flush");

        reg_write(6'h28, 32'h8000_0ABC);
        reg_write(6'h30, 32'h1234_5678);
        address = 6'h04; data_in = 32'h0003_0F0F; data_write_n = 2'b01;
        settle();
        data_write_n = 2'b11;
        settle();
        rd(6'h28, v); chk("code1.rb", v, 32'h8000_0ABC);
        rd(6'h30, v); chk("code2.unmapped", v, 32'd0);
        rd(6'h18, v); chk("unmapped", v, 32'd0);
        rd(6'h04, v); chk("narrow.ignored", v, {14'd0, m_oie, m_tie, 6'd0, m_fen, 4'd0, m_thresh});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
